// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a timed memory
// handshake, branch resolution, illegal-opcode and bus-error traps, retire count.
package multicycle_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02, OP_OR   = 6'h03,
        OP_XOR  = 6'h04, OP_SLL  = 6'h05, OP_SRL  = 6'h06,
        OP_ADDI = 6'h08, OP_ANDI = 6'h09, OP_ORI  = 6'h0A, OP_XORI = 6'h0B,
        OP_LUI  = 6'h0C,
        OP_LW   = 6'h10, OP_SW   = 6'h11, OP_LAD  = 6'h12, OP_LOA  = 6'h13,
        OP_JAL  = 6'h14,
        OP_BEQ  = 6'h20, OP_BNE  = 6'h21, OP_BGT  = 6'h22, OP_BGE  = 6'h23,
        OP_BLT  = 6'h24, OP_BLE  = 6'h25, OP_BGTU = 6'h26, OP_BGEU = 6'h27,
        OP_BLTU = 6'h28, OP_BLEU = 6'h29
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
        ALU_BSL, ALU_EQ, ALU_GRT, ALU_GTE, ALU_LTE, ALU_GTU, ALU_GEU, ALU_LEU
    } alu_opcode_t;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
    } state_t;

    typedef enum logic [2:0] {C_ALU, C_BR, C_JAL, C_LW, C_SW, C_LAD, C_LOA} iclass_t;

    typedef struct packed {
        iclass_t     cls;
        alu_opcode_t alu;
        logic        imm;
        logic        fb;
        logic        inv;
    } decode_t;

endpackage

module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  opcode_t          op,
    input  logic             alu_flag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             sel_PC,
    output logic             store_pc,
    output logic             reg_we,
    output logic             alu_imm,
    output logic             alu_bypass,
    output logic             alu_feedback_in,
    output logic             mem_we,
    output logic             mem_bypass,
    output logic             branch,
    output logic             jump,
    output alu_opcode_t      alu_ctrl,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    state_t           state_q, state_d;
    decode_t          dec_q, dec_d, dec_n;
    logic             dec_bad;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic             to_limit, taken;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dec_n   = '{cls: C_ALU, alu: ALU_NOP, imm: 1'b0, fb: 1'b0, inv: 1'b0};
        dec_bad = 1'b0;
        case (op)
            OP_ADD:  dec_n.alu = ALU_ADD;
            OP_SUB:  dec_n.alu = ALU_SUB;
            OP_AND:  dec_n.alu = ALU_AND;
            OP_OR:   dec_n.alu = ALU_OR;
            OP_XOR:  dec_n.alu = ALU_XOR;
            OP_SLL:  dec_n.alu = ALU_SLL;
            OP_SRL:  dec_n.alu = ALU_SRL;
            OP_ADDI: dec_n = '{cls: C_ALU, alu: ALU_ADD, imm: 1'b1, fb: 1'b1, inv: 1'b0};
            OP_ANDI: dec_n = '{cls: C_ALU, alu: ALU_AND, imm: 1'b1, fb: 1'b1, inv: 1'b0};
            OP_ORI:  dec_n = '{cls: C_ALU, alu: ALU_OR,  imm: 1'b1, fb: 1'b1, inv: 1'b0};
            OP_XORI: dec_n = '{cls: C_ALU, alu: ALU_XOR, imm: 1'b1, fb: 1'b1, inv: 1'b0};
            OP_LUI:  dec_n = '{cls: C_ALU, alu: ALU_BSL, imm: 1'b1, fb: 1'b0, inv: 1'b0};
            OP_LW:   begin dec_n.cls = C_LW;  dec_n.alu = ALU_ADD; end
            OP_SW:   begin dec_n.cls = C_SW;  dec_n.alu = ALU_ADD; end
            OP_LAD:  dec_n.cls = C_LAD;
            OP_LOA:  dec_n.cls = C_LOA;
            OP_JAL:  dec_n.cls = C_JAL;
            OP_BEQ:  begin dec_n.cls = C_BR; dec_n.alu = ALU_EQ; end
            OP_BNE:  begin dec_n.cls = C_BR; dec_n.alu = ALU_EQ;  dec_n.inv = 1'b1; end
            OP_BGT:  begin dec_n.cls = C_BR; dec_n.alu = ALU_GRT; end
            OP_BGE:  begin dec_n.cls = C_BR; dec_n.alu = ALU_GTE; end
            OP_BLT:  begin dec_n.cls = C_BR; dec_n.alu = ALU_GTE; dec_n.inv = 1'b1; end
            OP_BLE:  begin dec_n.cls = C_BR; dec_n.alu = ALU_LTE; end
            OP_BGTU: begin dec_n.cls = C_BR; dec_n.alu = ALU_GTU; end
            OP_BGEU: begin dec_n.cls = C_BR; dec_n.alu = ALU_GEU; end
            OP_BLTU: begin dec_n.cls = C_BR; dec_n.alu = ALU_GEU; dec_n.inv = 1'b1; end
            OP_BLEU: begin dec_n.cls = C_BR; dec_n.alu = ALU_LEU; end
            default: dec_bad = 1'b1;
        endcase
    end

    assign to_limit = (to_q == TO_W'(MEM_TIMEOUT - 1));
    assign taken    = alu_flag ^ dec_q.inv;

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        to_d      = to_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                to_d = mem_ready ? '0 : to_q + 1'b1;
                if (mem_ready) begin
                    if (state_q == S_FETCH)   state_d = S_DECODE;
                    else if (dec_q.cls == C_SW) begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + 1'b1;
                    end else                  state_d = S_WB;
                end else if (to_limit) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                dec_d = dec_n;
                if (dec_bad) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (dec_q.cls)
                    C_BR: begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + 1'b1;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        // A fresh memory phase always starts its wait budget from zero.
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
            to_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            dec_q     <= '0;
            to_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            to_q      <= to_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        mem_req = 1'b0; ir_we = 1'b0; pc_we = 1'b0; sel_PC = 1'b0;
        store_pc = 1'b0; reg_we = 1'b0; alu_imm = 1'b0; alu_bypass = 1'b0;
        alu_feedback_in = 1'b0; mem_we = 1'b0; mem_bypass = 1'b0;
        branch = 1'b0; jump = 1'b0; alu_ctrl = ALU_NOP;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_EXEC: begin
                    alu_ctrl        = dec_q.alu;
                    alu_imm         = dec_q.imm;
                    alu_feedback_in = dec_q.fb;
                    if (dec_q.cls == C_BR) begin
                        branch = 1'b1;
                        pc_we  = taken;
                        sel_PC = taken;
                    end else if (dec_q.cls == C_JAL) begin
                        jump   = 1'b1;
                        sel_PC = 1'b1;
                        pc_we  = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (dec_q.cls == C_SW) && mem_ready;
                end
                S_WB: begin
                    reg_we     = (dec_q.cls == C_LW) || (dec_q.cls == C_LAD) || (dec_q.cls == C_JAL);
                    store_pc   = (dec_q.cls == C_JAL);
                    mem_bypass = (dec_q.cls == C_LAD);
                    alu_bypass = (dec_q.cls == C_LOA);
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequencing, branches, memory
// waits and timeout, traps, reset recovery and retired-counter wrap (CNT_W=4).
module tb_multicycle_controller;
    import multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    opcode_t     op;
    logic        alu_flag, mem_ready;
    logic        mem_req, ir_we, pc_we, sel_PC, store_pc, reg_we, alu_imm;
    logic        alu_bypass, alu_feedback_in, mem_we, mem_bypass, branch, jump;
    alu_opcode_t alu_ctrl;
    logic        illegal, bus_err;
    logic [3:0]  retired;
    logic [2:0]  state_o;
    logic [16:0] ctrl_bus;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    multicycle_controller #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .alu_flag(alu_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we), .sel_PC(sel_PC),
        .store_pc(store_pc), .reg_we(reg_we), .alu_imm(alu_imm), .alu_bypass(alu_bypass),
        .alu_feedback_in(alu_feedback_in), .mem_we(mem_we), .mem_bypass(mem_bypass),
        .branch(branch), .jump(jump), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .bus_err(bus_err), .retired(retired), .state_o(state_o)
    );

    assign ctrl_bus = {mem_req, ir_we, pc_we, sel_PC, store_pc, reg_we, alu_imm, alu_bypass,
                       alu_feedback_in, mem_we, mem_bypass, branch, jump, alu_ctrl};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic retire_check(input string tag);
        exp_ret++;
        check({tag, "/state"}, state_o, 0);
        check({tag, "/retired"}, retired, exp_ret % 16);
    endtask

    // Fetch + decode with no memory wait, ending in EXEC.
    task automatic to_exec(input string tag, input opcode_t o);
        op = o; mem_ready = 1'b1; #1;
        check({tag, "/fetch"}, {state_o, mem_req, ir_we, pc_we, sel_PC}, {3'd0, 4'b1110});
        tick();
        check({tag, "/decode"}, {state_o, ctrl_bus}, {3'd1, 17'd0});
        tick();
        check({tag, "/exec"}, state_o, 2);
    endtask

    task automatic run_alu(input string tag, input opcode_t o, input alu_opcode_t ea,
                           input logic ei, input logic ef);
        to_exec(tag, o);
        check({tag, "/alu"}, alu_ctrl, ea);
        check({tag, "/imm_fb_we"}, {alu_imm, alu_feedback_in, reg_we, pc_we}, {ei, ef, 2'b00});
        tick();
        check({tag, "/wb"}, {state_o, reg_we}, {3'd4, 1'b0});
        tick();
        retire_check(tag);
    endtask

    task automatic run_branch(input string tag, input opcode_t o, input logic flag,
                              input alu_opcode_t ea, input logic t);
        to_exec(tag, o);
        alu_flag = flag; #1;
        check({tag, "/alu"}, alu_ctrl, ea);
        check({tag, "/br_pc_sel"}, {branch, pc_we, sel_PC, reg_we, mem_we}, {1'b1, t, t, 2'b00});
        tick();
        retire_check(tag);
    endtask

    initial begin
        rst_n = 1'b0; op = OP_ADD; alu_flag = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        check("reset/ctrl", ctrl_bus, 0);
        check("reset/status", {state_o, illegal, bus_err, retired}, 0);
        rst_n = 1'b1; #1;
        check("release/mem_req", {state_o, mem_req}, {3'd0, 1'b1});

        run_alu("add", OP_ADD, ALU_ADD, 1'b0, 1'b0);
        run_branch("bne_f0", OP_BNE, 1'b0, ALU_EQ, 1'b1);
        run_branch("bne_f1", OP_BNE, 1'b1, ALU_EQ, 1'b0);
        run_branch("bge_f1", OP_BGE, 1'b1, ALU_GTE, 1'b1);
        run_branch("bltu_f1", OP_BLTU, 1'b1, ALU_GEU, 1'b0);
        run_branch("ble_f0", OP_BLE, 1'b0, ALU_LTE, 1'b0);
        run_alu("addi", OP_ADDI, ALU_ADD, 1'b1, 1'b1);
        run_alu("lui", OP_LUI, ALU_BSL, 1'b1, 1'b0);

        // LW with three wait cycles in MEM: 8 cycles total.
        to_exec("lw", OP_LW);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("lw/mem", {state_o, mem_req, mem_we, reg_we}, {3'd3, 3'b100});
            if (i < 3) tick();
        end
        tick();
        check("lw/wb", {state_o, reg_we, store_pc}, {3'd4, 2'b10});
        tick();
        check("lw/after_wb_we", reg_we, 0);
        retire_check("lw");

        to_exec("sw", OP_SW);
        tick();
        check("sw/mem", {state_o, mem_req, mem_we}, {3'd3, 2'b11});
        tick();
        retire_check("sw");

        to_exec("jal", OP_JAL);
        check("jal/exec", {jump, sel_PC, pc_we}, 3'b111);
        tick();
        check("jal/wb", {state_o, reg_we, store_pc}, {3'd4, 2'b11});
        tick();
        retire_check("jal");

        // mem_ready on the 15th wait cycle still wins over the timeout.
        op = OP_ADD; mem_ready = 1'b0; #1;
        for (int i = 0; i < 14; i++) tick();
        check("race/still_fetch", {state_o, mem_req, bus_err}, {3'd0, 2'b10});
        mem_ready = 1'b1; #1;
        check("race/ir_we", ir_we, 1);
        tick();
        check("race/decode", {state_o, bus_err}, {3'd1, 1'b0});
        tick();
        tick();
        tick();
        retire_check("race");

        // Stuck memory: trap after 15 wait cycles.
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 14; i++) tick();
        check("timeout/at14", {state_o, bus_err}, {3'd0, 1'b0});
        tick();
        check("timeout/trap", {state_o, bus_err}, {3'd5, 1'b1});
        check("timeout/ctrl", ctrl_bus, 0);
        mem_ready = 1'b1; #1;
        tick();
        check("timeout/stays", {state_o, ctrl_bus}, {3'd5, 17'd0});

        rst_n = 1'b0; #1;
        check("rst2/ctrl_low", ctrl_bus, 0);
        tick();
        rst_n = 1'b1; #1;
        check("rst2/status", {state_o, bus_err, illegal, retired}, 0);
        check("rst2/mem_req", mem_req, 1);
        exp_ret = 0;

        for (int i = 0; i < 16; i++) run_alu("wrap", OP_XOR, ALU_XOR, 1'b0, 1'b0);
        check("wrap/zero", retired, 0);

        // Undefined opcode traps straight out of DECODE.
        op = opcode_t'(6'h3F); mem_ready = 1'b1; #1;
        tick();
        check("ill/decode", {state_o, pc_we, reg_we, mem_we, illegal}, {3'd1, 4'b0000});
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ill/trap", {state_o, illegal, pc_we, reg_we, mem_we}, {3'd5, 4'b1000});
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        check("ill/reset", {state_o, illegal}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
